// File: rtl/opl3_pkg.sv
// Shared OPL3 constants and helpers for the timer bank.
package opl3_pkg;

  // Default master clock and timer-bank configuration.
  localparam int unsigned CLK_FREQ        = 14318180;
  localparam int unsigned BASE_TICK_HZ    = 12500;
  localparam int unsigned TICK_RATIO_LOG2 = 2;
  localparam int unsigned NUM_TIMERS      = 2;
  localparam int unsigned COUNTER_WIDTH   = 8;
  localparam int unsigned ACC_WIDTH       = 32;

  // Rounded phase increment: round(tick_hz * 2^acc_w / clk_hz).
  function automatic longint unsigned calc_phase_inc(
    input longint unsigned clk_hz,
    input longint unsigned tick_hz,
    input int unsigned     acc_w
  );
    longint unsigned num;
    if (clk_hz == 64'd0) begin
      return 64'd0;
    end
    num = (tick_hz << acc_w) + (clk_hz >> 1);
    return num / clk_hz;
  endfunction

endpackage

// File: rtl/opl3_frac_tick_gen.sv
// Drift-free fractional tick generator: a phase accumulator whose carry-out
// is registered as a one-cycle tick pulse.
module opl3_frac_tick_gen #(
  parameter int unsigned CLK_FREQ  = opl3_pkg::CLK_FREQ,
  parameter int unsigned TICK_HZ   = opl3_pkg::BASE_TICK_HZ,
  parameter int unsigned ACC_WIDTH = opl3_pkg::ACC_WIDTH
) (
  input  logic clk,
  input  logic ic_n,
  output logic tick
);
  import opl3_pkg::*;

  localparam longint unsigned INC     = calc_phase_inc(64'(CLK_FREQ), 64'(TICK_HZ), ACC_WIDTH);
  localparam longint unsigned ACC_MOD = 64'(1) << ACC_WIDTH;

  // Reject configurations that would never tick or would tick every cycle.
  if (ACC_WIDTH < 1 || ACC_WIDTH > 63) begin : g_bad_acc_width
    $error("opl3_frac_tick_gen: ACC_WIDTH must be 1..63");
  end
  if (INC == 64'd0 || INC >= ACC_MOD) begin : g_bad_inc
    $error("opl3_frac_tick_gen: phase increment out of range");
  end

  localparam logic [ACC_WIDTH-1:0] INC_W = ACC_WIDTH'(INC);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic                 carry_d;
  logic                 tick_q;

  // Next accumulator value and carry-out (wraps modulo 2^ACC_WIDTH).
  always_comb begin
    {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, INC_W};
  end

  // Accumulator and registered carry.
  always_ff @(posedge clk) begin
    if (!ic_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= carry_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/opl3_timer_bank.sv
// OPL3-style interval timer bank: NUM_TIMERS up-counting reload timers,
// each 2^TICK_RATIO_LOG2 times slower than the previous, with per-timer
// start/mask, overflow flags and a shared registered IRQ.
module opl3_timer_bank #(
  parameter int unsigned CLK_FREQ        = opl3_pkg::CLK_FREQ,
  parameter int unsigned BASE_TICK_HZ    = opl3_pkg::BASE_TICK_HZ,
  parameter int unsigned TICK_RATIO_LOG2 = opl3_pkg::TICK_RATIO_LOG2,
  parameter int unsigned NUM_TIMERS      = opl3_pkg::NUM_TIMERS,
  parameter int unsigned COUNTER_WIDTH   = opl3_pkg::COUNTER_WIDTH,
  parameter int unsigned ACC_WIDTH       = opl3_pkg::ACC_WIDTH
) (
  input  logic                                                    clk,
  input  logic                                                    ic_n,
  input  logic                                                    wr_en,
  input  logic [(NUM_TIMERS > 1 ? $clog2(NUM_TIMERS) : 1)-1:0]    wr_sel,
  input  logic [COUNTER_WIDTH-1:0]                                wr_data,
  input  logic [NUM_TIMERS-1:0]                                   start,
  input  logic [NUM_TIMERS-1:0]                                   mask,
  input  logic                                                    irq_rst,
  output logic [NUM_TIMERS-1:0]                                   flag,
  output logic                                                    irq,
  output logic                                                    base_tick
);

  localparam int unsigned SEL_W     = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;
  localparam int unsigned PRE_W_RAW = (NUM_TIMERS - 1) * TICK_RATIO_LOG2;
  localparam int unsigned PRE_W     = (PRE_W_RAW > 0) ? PRE_W_RAW : 1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  if (NUM_TIMERS < 1 || NUM_TIMERS > 8) begin : g_bad_num_timers
    $error("opl3_timer_bank: NUM_TIMERS must be 1..8");
  end

  logic                  base_tick_w;
  logic [PRE_W-1:0]      pre_q;
  logic [PRE_W-1:0]      pre_d;
  logic [NUM_TIMERS-1:0] tick_vec;
  logic [NUM_TIMERS-1:0] ovf_vec;
  logic [NUM_TIMERS-1:0] start_q;
  logic [NUM_TIMERS-1:0] flag_q;
  logic [NUM_TIMERS-1:0] flag_d;
  logic                  irq_q;

  // Base tick source for timer 0 and the prescaler.
  opl3_frac_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .TICK_HZ   (BASE_TICK_HZ),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_tick_gen (
    .clk  (clk),
    .ic_n (ic_n),
    .tick (base_tick_w)
  );

  assign base_tick = base_tick_w;

  // Free-running prescaler advanced by each base tick.
  always_comb begin
    pre_d = pre_q;
    if (base_tick_w) begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (!ic_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_timer
    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [COUNTER_WIDTH-1:0] cnt_d;
    logic [COUNTER_WIDTH-1:0] rld_q;
    logic [COUNTER_WIDTH-1:0] rld_d;
    logic                     ovf_c;

    // Timer i ticks when the low i*TICK_RATIO_LOG2 prescaler bits are all ones.
    if (i == 0 || TICK_RATIO_LOG2 == 0) begin : g_tick_base
      assign tick_vec[i] = base_tick_w;
    end else begin : g_tick_div
      assign tick_vec[i] = base_tick_w & (&pre_q[i*TICK_RATIO_LOG2-1:0]);
    end

    // Reload write, start-edge load, counting and overflow reload.
    always_comb begin
      cnt_d = cnt_q;
      rld_d = rld_q;
      ovf_c = 1'b0;
      if (wr_en && (wr_sel == SEL_W'(i))) begin
        rld_d = wr_data;
      end
      if (start[i] && !start_q[i]) begin
        cnt_d = rld_q;
      end else if (start[i] && tick_vec[i]) begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = rld_q;
          ovf_c = 1'b1;
        end else begin
          cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
      end
    end

    // Counter and reload registers.
    always_ff @(posedge clk) begin
      if (!ic_n) begin
        cnt_q <= '0;
        rld_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        rld_q <= rld_d;
      end
    end

    assign ovf_vec[i] = ovf_c;
  end

  // Flag update: clear and mask first, then a non-masked overflow sets.
  always_comb begin
    flag_d = flag_q;
    if (irq_rst) begin
      flag_d = '0;
    end
    flag_d = flag_d & ~mask;
    flag_d = flag_d | (ovf_vec & ~mask);
  end

  // Flags, IRQ and start history.
  always_ff @(posedge clk) begin
    if (!ic_n) begin
      flag_q  <= '0;
      irq_q   <= 1'b0;
      start_q <= '0;
    end else begin
      flag_q  <= flag_d;
      irq_q   <= |flag_d;
      start_q <= start;
    end
  end

  assign flag = flag_q;
  assign irq  = irq_q;

endmodule
